// File: rtl/div_unit_pkg.sv
// Shared divider definitions: bus widths, reset/handshake levels and FSM state encodings.
// Pure declarations; no latency or backpressure of its own.
package div_unit_pkg;

    localparam int          RegBus            = 32;
    localparam int          DoubleRegBus      = 2 * RegBus;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam logic        RstEnable         = 1'b1;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage to divider request/result bundle; EX is master, the divider is slave.
// Result is held by the slave for as long as start_i stays high.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int DATA_W = RegBus
);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial-subtract the divisor, keep the difference if non-negative.
// Purely combinational, zero latency, no flow control.
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic [DATA_W:0]   trial_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              qbit_o
);
    logic [DATA_W:0] diff;

    // trial_i < 2*divisor, so the sign of the (DATA_W+1)-bit difference is exact.
    always_comb begin
        diff   = trial_i - {1'b0, divisor_i};
        qbit_o = ~diff[DATA_W];
        rem_o  = qbit_o ? diff[DATA_W-1:0] : trial_i[DATA_W-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU: ready_o after DATA_W+1 edges (1 for divide-by-zero), held while start_i stays high.
// Optional DIV_EARLY_OUT_EN: dividend magnitude below divisor magnitude finishes in one edge.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*DATA_W-1:0]  p_q, p_d;
    logic [DATA_W-1:0]    div_q, div_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [2*DATA_W-1:0]  result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 neg1, neg2;
    logic [DATA_W-1:0]    mag1, mag2;
    logic                 accept, div_zero, short_path;
    logic                 last_iter;
    logic [DATA_W-1:0]    rem_cur, quo_cur, rem_next;
    logic                 qbit;

    assign neg1     = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign neg2     = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign mag1     = neg1 ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2     = neg2 ? -bus.opdata2_i : bus.opdata2_i;
    assign accept   = (bus.start_i == DivStart) && !bus.annul_i;
    assign div_zero = (bus.opdata2_i == '0);
`ifdef DIV_EARLY_OUT_EN
    assign short_path = div_zero || (mag1 < mag2);
`else
    assign short_path = div_zero;
`endif

    assign last_iter = (cnt_q == CNT_W'(DATA_W));
    assign rem_cur   = p_q[2*DATA_W-1:DATA_W];
    assign quo_cur   = p_q[DATA_W-1:0];

    div_step #(.DATA_W(DATA_W)) u_step (
        .trial_i   (p_q[2*DATA_W-1:DATA_W-1]),
        .divisor_i (div_q),
        .rem_o     (rem_next),
        .qbit_o    (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            p_q      <= '0;
            div_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            div_q    <= div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.annul_i) begin
            state_d = DivFree;
        end else begin
            unique case (state_q)
                DivFree:   if (accept) state_d = short_path ? DivByZero : DivOn;
                DivByZero: state_d = DivEnd;
                DivOn:     if (last_iter) state_d = DivEnd;
                DivEnd:    if (bus.start_i == DivStop) state_d = DivFree;
                default:   state_d = DivFree;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        p_d      = p_q;
        div_d    = div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;
        if (bus.annul_i) begin
            result_d = '0;
            ready_d  = DivResultNotReady;
        end else begin
            unique case (state_q)
                DivFree: begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    if (accept) begin
                        negq_d = neg1 ^ neg2;
                        negr_d = neg1;
                        div_d  = mag2;
                        cnt_d  = '0;
                        // Short path parks its final result in p_q: zero for /0, raw dividend as remainder otherwise.
                        if (div_zero)        p_d = '0;
                        else if (short_path) p_d = {bus.opdata1_i, {DATA_W{1'b0}}};
                        else                 p_d = {{DATA_W{1'b0}}, mag1};
                    end
                end
                DivByZero: begin
                    result_d = p_q;
                    ready_d  = DivResultReady;
                end
                DivOn: begin
                    if (last_iter) begin
                        result_d = {negr_q ? -rem_cur : rem_cur, negq_q ? -quo_cur : quo_cur};
                        ready_d  = DivResultReady;
                    end else begin
                        p_d   = {rem_next, p_q[DATA_W-2:0], qbit};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        result_d = '0;
                        ready_d  = DivResultNotReady;
                    end
                end
                default: begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, hold/release, annul, reset abort, overflow, short path.
`timescale 1ns/1ps
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a divide, scramble operands after acceptance, measure edges to ready_o.
    task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int n;
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        wait_edges(1);
        bus.opdata1_i = ~a;
        bus.opdata2_i = b ^ 32'h0000_0005;
        bus.signed_div_i = ~sg;
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 40) begin
            wait_edges(1);
            n++;
        end
        total++;
        if (n != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, n, exp_lat);
        end
        total++;
        if (bus.result_o !== exp_res) begin
            bad++;
            $display("FAIL %s result: got %h, expected %h", name, bus.result_o, exp_res);
        end
    endtask

    task automatic release_start(input string name);
        bus.start_i = 1'b0;
        wait_edges(1);
        total++;
        if (bus.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s release ready: got %b, expected 0", name, bus.ready_o);
        end
        total++;
        if (bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL %s release result: got %h, expected 0", name, bus.result_o);
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            wait_edges(1);
            if (bus.ready_o !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s idle: ready_o high on %0d edges, expected 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'h0;
        bus.opdata2_i = 32'h0;
        wait_edges(3);
        total++;
        if (bus.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset ready: got %b, expected 0", bus.ready_o);
        end
        total++;
        if (bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL reset result: got %h, expected 0", bus.result_o);
        end
        rst = 1'b0;
        wait_edges(1);
    endtask

    task automatic test_unsigned_hold();
        run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        for (int i = 0; i < 5; i++) begin
            wait_edges(1);
            total++;
            if (bus.ready_o !== 1'b1) begin
                bad++;
                $display("FAIL hold ready cycle %0d: got %b, expected 1", i, bus.ready_o);
            end
            total++;
            if (bus.result_o !== {32'd2, 32'd14}) begin
                bad++;
                $display("FAIL hold result cycle %0d: got %h, expected %h", i, bus.result_o, {32'd2, 32'd14});
            end
        end
        release_start("udiv_100_7");
    endtask

    task automatic test_signed();
        run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_start("sdiv_m7_2");
        run_div("sdiv_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
        release_start("sdiv_7_m2");
    endtask

    task automatic test_div_zero();
        run_div("div_by_zero", 1'b0, 32'd5, 32'd0, 1, 64'h0);
        release_start("div_by_zero");
    endtask

    task automatic test_annul();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        wait_edges(10);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        wait_edges(1);
        bus.annul_i = 1'b0;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL annul outputs: got ready=%b result=%h, expected 0/0", bus.ready_o, bus.result_o);
        end
        expect_idle("annul", 40);
        run_div("udiv_ffffffff_10", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 33, {32'h0000_000F, 32'h0FFF_FFFF});
        release_start("udiv_ffffffff_10");
    endtask

    task automatic test_rst_abort();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd12345;
        bus.opdata2_i = 32'd17;
        bus.start_i = 1'b1;
        wait_edges(20);
        rst = 1'b1;
        bus.start_i = 1'b0;
        wait_edges(1);
        rst = 1'b0;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL rst_abort outputs: got ready=%b result=%h, expected 0/0", bus.ready_o, bus.result_o);
        end
        expect_idle("rst_abort", 40);
        run_div("sdiv_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
        release_start("sdiv_overflow");
    endtask

    task automatic test_early_out();
        int lat;
`ifdef DIV_EARLY_OUT_EN
        lat = 1;
`else
        lat = 33;
`endif
        run_div("udiv_3_10", 1'b0, 32'd3, 32'd10, lat, {32'd3, 32'd0});
        release_start("udiv_3_10");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_hold();
        test_signed();
        test_div_zero();
        test_annul();
        test_rst_abort();
        test_early_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
